// File: rtl/mmc3_if.sv
// CPU/PPU-facing bus of the shared MMC3 mapper core.
// The master drives the CPU/PPU side; the slave is the mapper core.
interface mmc3_if #(
    parameter int PRG_BW = 6,
    parameter int CHR_BW = 8
);
    logic              m2_edge;
    logic              cpu_we;
    logic [15:0]       cpu_addr;
    logic [7:0]        cpu_dat;
    logic [13:0]       ppu_addr;
    logic [PRG_BW-1:0] prg_bank;
    logic [CHR_BW-1:0] chr_bank;
    logic              mir_h;
    logic              ram_en;
    logic              ram_wp;
    logic              irq;

    modport master (
        output m2_edge, cpu_we, cpu_addr, cpu_dat, ppu_addr,
        input  prg_bank, chr_bank, mir_h, ram_en, ram_wp, irq
    );

    modport slave (
        input  m2_edge, cpu_we, cpu_addr, cpu_dat, ppu_addr,
        output prg_bank, chr_bank, mir_h, ram_en, ram_wp, irq
    );
endinterface

// File: rtl/mmc3_core.sv
// Shared MMC3-family core: bank registers, mode bits, PRG-RAM control and
// the A12-clocked scanline IRQ counter, with raw bank numbers for wrappers.
module mmc3_core #(
    parameter int PRG_BW   = 6,
    parameter int CHR_BW   = 8,
    parameter bit IRQ_OLD  = 1'b0,
    parameter int A12_FILT = 3
) (
    input logic   clk,
    input logic   rst,
    mmc3_if.slave bus
);
    localparam logic [2:0]        FILT  = 3'(A12_FILT);
    localparam logic [PRG_BW-1:0] LAST  = '1;
    localparam logic [PRG_BW-1:0] SLAST = LAST - PRG_BW'(1);

    logic [7:0]        bank [8];
    logic [2:0]        bank_sel;
    logic              prg_mode;
    logic              chr_mode;
    logic              mir_h;
    logic              ram_en;
    logic              ram_wp;
    logic [7:0]        latch;
    logic [7:0]        counter;
    logic              reload_flag;
    logic              irq_en;
    logic              irq;
    logic [2:0]        low_cnt;
    logic              a12_prev;

    logic              wr;
    logic [2:0]        reg_sel;
    logic              a12;
    logic              edge_seen;
    logic              edge_ok;
    logic              reload_now;
    logic [7:0]        counter_next;
    logic              irq_set;
    logic [PRG_BW-1:0] prg;
    logic [2:0]        chr_sel;
    logic [7:0]        chr_raw;
    logic              unused_bits;

    assign wr           = bus.cpu_we & bus.cpu_addr[15];
    assign reg_sel      = {bus.cpu_addr[14:13], bus.cpu_addr[0]};
    assign a12          = bus.ppu_addr[12];
    assign edge_seen    = a12 & ~a12_prev & (low_cnt >= FILT);
    // A $C001 write in the same clk swallows the edge entirely.
    assign edge_ok      = edge_seen & ~(wr & (reg_sel == 3'b101));
    assign reload_now   = (counter == 8'd0) | reload_flag;
    assign counter_next = reload_now ? latch : counter - 8'd1;
    assign irq_set      = edge_ok & (counter_next == 8'd0) & irq_en &
                          (~IRQ_OLD | (counter != 8'd0) | reload_flag);
    assign unused_bits  = &{1'b0, bus.cpu_addr[12:1], bus.ppu_addr[13], bus.ppu_addr[9:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            bank     <= '{8'd0, 8'd2, 8'd4, 8'd5, 8'd6, 8'd7, 8'd0, 8'd1};
            bank_sel <= 3'd0;
            prg_mode <= 1'b0;
            chr_mode <= 1'b0;
            mir_h    <= 1'b0;
            ram_en   <= 1'b0;
            ram_wp   <= 1'b0;
            latch    <= 8'd0;
            irq_en   <= 1'b0;
        end else if (wr) begin
            case (reg_sel)
                3'b000: begin
                    bank_sel <= bus.cpu_dat[2:0];
                    prg_mode <= bus.cpu_dat[6];
                    chr_mode <= bus.cpu_dat[7];
                end
                3'b001: bank[bank_sel] <= bus.cpu_dat;
                3'b010: mir_h <= bus.cpu_dat[0];
                3'b011: begin
                    ram_en <= bus.cpu_dat[7];
                    ram_wp <= bus.cpu_dat[6];
                end
                3'b100: latch <= bus.cpu_dat;
                3'b110: irq_en <= 1'b0;
                3'b111: irq_en <= 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            low_cnt  <= 3'd0;
            a12_prev <= 1'b0;
        end else begin
            a12_prev <= a12;
            if (a12)
                low_cnt <= 3'd0;
            else if (bus.m2_edge && low_cnt < FILT)
                low_cnt <= low_cnt + 3'd1;
        end
    end

    // An $E000 write beats a simultaneous IRQ set.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter     <= 8'd0;
            reload_flag <= 1'b0;
            irq         <= 1'b0;
        end else begin
            if (wr && reg_sel == 3'b101) begin
                counter     <= 8'd0;
                reload_flag <= 1'b1;
            end else if (edge_ok) begin
                counter     <= counter_next;
                reload_flag <= 1'b0;
            end
            if (wr && reg_sel == 3'b110)
                irq <= 1'b0;
            else if (irq_set)
                irq <= 1'b1;
        end
    end

    always_comb begin
        prg     = LAST;
        chr_sel = bus.ppu_addr[12:10] ^ {chr_mode, 2'b00};
        chr_raw = 8'd0;
        case (bus.cpu_addr[14:13])
            2'd0:    prg = prg_mode ? SLAST : PRG_BW'(bank[6]);
            2'd1:    prg = PRG_BW'(bank[7]);
            2'd2:    prg = prg_mode ? PRG_BW'(bank[6]) : SLAST;
            default: prg = LAST;
        endcase
        case (chr_sel)
            3'd0:    chr_raw = {bank[0][7:1], 1'b0};
            3'd1:    chr_raw = {bank[0][7:1], 1'b1};
            3'd2:    chr_raw = {bank[1][7:1], 1'b0};
            3'd3:    chr_raw = {bank[1][7:1], 1'b1};
            3'd4:    chr_raw = bank[2];
            3'd5:    chr_raw = bank[3];
            3'd6:    chr_raw = bank[4];
            default: chr_raw = bank[5];
        endcase
    end

    assign bus.prg_bank = prg;
    assign bus.chr_bank = CHR_BW'(chr_raw);
    assign bus.mir_h    = mir_h;
    assign bus.ram_en   = ram_en;
    assign bus.ram_wp   = ram_wp;
    assign bus.irq      = irq;
endmodule

// File: tb/tb_mmc3_core.sv
// Directed bench for mmc3_core: one MMC3B and one MMC3A instance share the
// same stimulus so the two IRQ flavours can be compared side by side.
module tb_mmc3_core;
    logic        clk = 1'b0;
    logic        rst;
    logic        m2_edge;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dat;
    logic [13:0] ppu_addr;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    mmc3_if #(.PRG_BW(6), .CHR_BW(8)) bus_n ();
    mmc3_if #(.PRG_BW(6), .CHR_BW(8)) bus_o ();

    assign bus_n.m2_edge  = m2_edge;
    assign bus_n.cpu_we   = cpu_we;
    assign bus_n.cpu_addr = cpu_addr;
    assign bus_n.cpu_dat  = cpu_dat;
    assign bus_n.ppu_addr = ppu_addr;
    assign bus_o.m2_edge  = m2_edge;
    assign bus_o.cpu_we   = cpu_we;
    assign bus_o.cpu_addr = cpu_addr;
    assign bus_o.cpu_dat  = cpu_dat;
    assign bus_o.ppu_addr = ppu_addr;

    mmc3_core #(.PRG_BW(6), .CHR_BW(8), .IRQ_OLD(1'b0), .A12_FILT(3)) dut_new (
        .clk(clk), .rst(rst), .bus(bus_n.slave)
    );
    mmc3_core #(.PRG_BW(6), .CHR_BW(8), .IRQ_OLD(1'b1), .A12_FILT(3)) dut_old (
        .clk(clk), .rst(rst), .bus(bus_o.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-clk CPU register write.
    task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] dat);
        cpu_addr = addr;
        cpu_dat  = dat;
        cpu_we   = 1'b1;
        tick();
        cpu_we   = 1'b0;
    endtask

    task automatic m2Pulses(input int n);
        for (int i = 0; i < n; i++) begin
            m2_edge = 1'b1;
            tick();
            m2_edge = 1'b0;
        end
    endtask

    // n m2 strobes with A12 low, then one A12 rise and fall.
    task automatic a12Rise(input int n);
        m2Pulses(n);
        ppu_addr[12] = 1'b1;
        tick();
        ppu_addr[12] = 1'b0;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkIrq(input string tag, input logic exp_new, input logic exp_old);
        checkOutput({tag, "_new"}, 32'(bus_n.irq), 32'(exp_new));
        checkOutput({tag, "_old"}, 32'(bus_o.irq), 32'(exp_old));
    endtask

    initial begin
        rst      = 1'b1;
        m2_edge  = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0000;
        cpu_dat  = 8'h00;
        ppu_addr = 14'h0000;
        tick();
        tick();
        rst = 1'b0;

        // Reset mapping
        cpu_addr = 16'h8000; #1;
        checkOutput("rst_prg8000", 32'(bus_n.prg_bank), 32'd0);
        cpu_addr = 16'hA000; #1;
        checkOutput("rst_prgA000", 32'(bus_n.prg_bank), 32'd1);
        cpu_addr = 16'hC000; #1;
        checkOutput("rst_prgC000", 32'(bus_n.prg_bank), 32'd62);
        cpu_addr = 16'hE000; #1;
        checkOutput("rst_prgE000", 32'(bus_n.prg_bank), 32'd63);
        ppu_addr = 14'h1C00; #1;
        checkOutput("rst_chr1C00", 32'(bus_n.chr_bank), 32'd7);
        checkOutput("rst_mir_h", 32'(bus_n.mir_h), 32'd0);
        checkOutput("rst_ram_en", 32'(bus_n.ram_en), 32'd0);
        checkOutput("rst_ram_wp", 32'(bus_n.ram_wp), 32'd0);
        checkIrq("rst_irq", 1'b0, 1'b0);

        // Bank registers and PRG/CHR modes
        applyStimulus(16'h8000, 8'h46);
        applyStimulus(16'h8001, 8'h05);
        cpu_addr = 16'hC000; #1;
        checkOutput("prg1_C000", 32'(bus_n.prg_bank), 32'd5);
        cpu_addr = 16'h8000; #1;
        checkOutput("prg1_8000", 32'(bus_n.prg_bank), 32'd62);
        cpu_addr = 16'hA000; #1;
        checkOutput("prg1_A000", 32'(bus_n.prg_bank), 32'd1);
        applyStimulus(16'h8000, 8'h80);
        ppu_addr = 14'h0000; #1;
        checkOutput("chr1_0000", 32'(bus_n.chr_bank), 32'd4);
        cpu_addr = 16'h8000; #1;
        checkOutput("prg0_8000", 32'(bus_n.prg_bank), 32'd5);
        applyStimulus(16'h8001, 8'h0B);
        ppu_addr = 14'h1000; #1;
        checkOutput("chr1_1000", 32'(bus_n.chr_bank), 32'd10);
        ppu_addr = 14'h1400; #1;
        checkOutput("chr1_1400", 32'(bus_n.chr_bank), 32'd11);
        ppu_addr = 14'h0000;
        tick();

        // Mirroring, RAM control, writes below $8000 ignored
        applyStimulus(16'hA000, 8'h01);
        applyStimulus(16'hA001, 8'hC0);
        checkOutput("mir_h_set", 32'(bus_n.mir_h), 32'd1);
        checkOutput("ram_en_set", 32'(bus_n.ram_en), 32'd1);
        checkOutput("ram_wp_set", 32'(bus_n.ram_wp), 32'd1);
        applyStimulus(16'h2000, 8'h00);
        checkOutput("low_write_ignored", 32'(bus_n.mir_h), 32'd1);

        // Latch 3: edges give 3,2,1,0, IRQ on the fourth
        applyStimulus(16'hC000, 8'd3);
        applyStimulus(16'hC001, 8'd0);
        applyStimulus(16'hE001, 8'd0);
        a12Rise(4);
        checkIrq("cnt3_e1", 1'b0, 1'b0);
        a12Rise(4);
        checkIrq("cnt3_e2", 1'b0, 1'b0);
        a12Rise(4);
        checkIrq("cnt3_e3", 1'b0, 1'b0);
        a12Rise(4);
        checkIrq("cnt3_e4", 1'b1, 1'b1);
        applyStimulus(16'hE000, 8'd0);
        checkIrq("e000_clear", 1'b0, 1'b0);

        // Latch 0: old vs new semantics
        applyStimulus(16'hC000, 8'd0);
        applyStimulus(16'hC001, 8'd0);
        applyStimulus(16'hE001, 8'd0);
        a12Rise(4);
        checkIrq("latch0_e1", 1'b1, 1'b1);
        applyStimulus(16'hE000, 8'd0);
        applyStimulus(16'hE001, 8'd0);
        a12Rise(4);
        checkIrq("latch0_e2", 1'b1, 1'b0);

        // Edges before the filter threshold are ignored
        applyStimulus(16'hE000, 8'd0);
        applyStimulus(16'hE001, 8'd0);
        applyStimulus(16'hC000, 8'd1);
        applyStimulus(16'hC001, 8'd0);
        a12Rise(4);
        checkIrq("filt_load", 1'b0, 1'b0);
        a12Rise(1);
        a12Rise(1);
        a12Rise(1);
        checkIrq("filt_short", 1'b0, 1'b0);
        a12Rise(4);
        checkIrq("filt_good", 1'b1, 1'b1);

        // $C001 coincident with a qualified edge
        applyStimulus(16'hE000, 8'd0);
        applyStimulus(16'hE001, 8'd0);
        applyStimulus(16'hC001, 8'd0);
        a12Rise(4);
        checkIrq("coinc_load", 1'b0, 1'b0);
        m2Pulses(4);
        ppu_addr[12] = 1'b1;
        applyStimulus(16'hC001, 8'd0);
        ppu_addr[12] = 1'b0;
        tick();
        checkIrq("coinc_c001", 1'b0, 1'b0);
        a12Rise(4);
        checkIrq("coinc_reload", 1'b0, 1'b0);
        a12Rise(4);
        checkIrq("coinc_zero", 1'b1, 1'b1);

        // $E000 coincident with an IRQ set condition
        applyStimulus(16'hE000, 8'd0);
        applyStimulus(16'hE001, 8'd0);
        a12Rise(4);
        m2Pulses(4);
        ppu_addr[12] = 1'b1;
        applyStimulus(16'hE000, 8'd0);
        ppu_addr[12] = 1'b0;
        tick();
        checkIrq("coinc_e000", 1'b0, 1'b0);

        // Reset mid-count with IRQ pending
        applyStimulus(16'hE001, 8'd0);
        a12Rise(4);
        a12Rise(4);
        applyStimulus(16'h8000, 8'hC7);
        checkIrq("pre_rst_irq", 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cpu_addr = 16'h8000; #1;
        checkOutput("rst2_prg8000", 32'(bus_n.prg_bank), 32'd0);
        ppu_addr = 14'h1C00; #1;
        checkOutput("rst2_chr1C00", 32'(bus_n.chr_bank), 32'd7);
        checkOutput("rst2_mir_h", 32'(bus_n.mir_h), 32'd0);
        checkOutput("rst2_ram_en", 32'(bus_n.ram_en), 32'd0);
        checkOutput("rst2_ram_wp", 32'(bus_n.ram_wp), 32'd0);
        checkIrq("rst2_irq", 1'b0, 1'b0);
        ppu_addr = 14'h0000;
        tick();
        applyStimulus(16'hE001, 8'd0);
        a12Rise(4);
        checkIrq("rst2_counter", 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mmc3_core.md
Name: mmc3_core

Overview:
Parametrised, shared MMC3-family mapper core that replaces the per-variant bank/IRQ logic duplicated across the MMC3-derived mappers (012, 047, 064, 115, 118, 119, 189, 196, 205 …).
- Holds the eight bank registers, mode bits, mirroring, PRG-RAM protect and the scanline IRQ counter.
- Exposes raw 8 KB PRG and 1 KB CHR bank numbers for per-mapper wrappers to remap or extend.
- Selects MMC3A ("old") or MMC3B ("new") IRQ semantics by parameter.

Parameters:
PRG_BW, 6, width of PRG bank number (8 KB units)
CHR_BW, 8, width of CHR bank number (1 KB units)
IRQ_OLD, 0, 0 = MMC3B IRQ semantics, 1 = MMC3A IRQ semantics
A12_FILT, 3, number of m2_edge strobes A12 must stay low before a rising edge is counted (1..7)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
m2_edge  in  1  one-clk strobe per CPU cycle
cpu_we  in  1  one-clk strobe, CPU write to cpu_addr
cpu_addr  in  16  CPU address
cpu_dat  in  8  CPU write data
ppu_addr  in  14  PPU address (bit 12 = A12)
prg_bank  out  PRG_BW  8 KB bank for cpu_addr[14:13]
chr_bank  out  CHR_BW  1 KB bank for ppu_addr[12:10]
mir_h  out  1  1 = horizontal mirroring
ram_en  out  1  PRG-RAM chip enable allowed
ram_wp  out  1  PRG-RAM write protect
irq  out  1  active-high IRQ request (level)

Behaviour:
Reset values:
- R0..R7 = 0,2,4,5,6,7,0,1; bank_sel = 0; prg_mode = 0; chr_mode = 0.
- mir_h = 0, ram_en = 0, ram_wp = 0.
- latch = 0, counter = 0, reload_flag = 0, irq_en = 0, irq = 0, A12 low-count = 0.
- Reset overrides all events in the same clk.

Register writes:
- Accepted only when cpu_we=1 and cpu_addr[15]=1.
- Decode uses cpu_addr[14:13] and cpu_addr[0].
- New state is visible on outputs the clk after the strobe. Outputs are combinational from registered state plus the current address.
- $8000 even: bank_sel = dat[2:0], prg_mode = dat[6], chr_mode = dat[7].
- $8001 odd: R[bank_sel] = dat (truncated to the bank width).
- $A000 even: mir_h = dat[0].
- $A001 odd: ram_en = dat[7], ram_wp = dat[6].
- $C000 even: latch = dat.
- $C001 odd: counter = 0, reload_flag = 1.
- $E000 even: irq_en = 0, irq = 0.
- $E001 odd: irq_en = 1.

PRG mapping (slot = cpu_addr[14:13], LAST = all-ones, SLAST = LAST-1):
- prg_mode=0: R6, R7, SLAST, LAST.
- prg_mode=1: SLAST, R7, R6, LAST.

CHR mapping:
- s = ppu_addr[12:10] XOR {chr_mode,2'b00}.
- s=0: R0 & ~1; s=1: R0 | 1; s=2: R1 & ~1; s=3: R1 | 1; s=4..7: R2..R5.

A12 filter:
- Count m2_edge strobes while A12 = 0, saturating at A12_FILT. Counter clears when A12 = 1.
- A qualified edge is A12 going 0→1 (registered previous sample) with count ≥ A12_FILT.
- Edges arriving before the threshold are ignored.

Counter (on a qualified edge):
- If counter==0 or reload_flag: counter = latch, reload_flag = 0. Otherwise counter = counter - 1 (8-bit, no wrap possible).
- IRQ_OLD=0: irq set if next counter==0 and irq_en.
- IRQ_OLD=1: irq set if next counter==0 and irq_en and (previous counter != 0 or reload_flag was 1).
- irq stays high until a $E000 write or reset.

Simultaneous events:
- $C001 write and qualified edge in the same clk: the write wins and the edge is dropped.
- $E000 write and IRQ set condition in the same clk: irq = 0.
- $E001 in the same clk as an edge: the edge sees the old irq_en.

Test Plan:
- Reset then read: cpu_addr=$8000 → prg_bank=0; $C000 → SLAST=62; $E000 → 63; ppu_addr=$1C00 → chr_bank=7; irq=0, ram_en=0.
- Write $8000=$46, $8001=$05, then cpu_addr=$C000 → prg_bank=5; cpu_addr=$8000 → 62. Write $8000=$80, ppu_addr=$0000 → chr_bank=R2=4.
- Latch=3, $C001, $E001, with A12 pulses spaced by 4 m2_edge → edges 1..4 produce counter 3,2,1,0; irq rises on the 4th edge. Write $E000 → irq falls the next clk.
- Latch=0, $C001, $E001, one qualified edge → IRQ_OLD=0: irq=1. IRQ_OLD=1 (flag set): irq=1. A second edge with counter already 0: IRQ_OLD=0 re-asserts, IRQ_OLD=1 does not.
- A12 toggled with only 1 m2_edge low between rises (A12_FILT=3) → counter unchanged, irq stays 0.
- $C001 write and a qualified edge in the same clk → counter=0 and reload_flag=1; the next edge loads the latch. Assert rst mid-count → all reset values the next clk.
